// File: rtl/mem_port_arbiter.sv
// Arbitrates the single 16-bit memory port between the CPU and a DMA/debug requester.
// The CPU has priority, limited by a hold counter. Reads return data after MEM_LATENCY cycles.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 1,
  parameter int MAX_HOLD    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_byte_half,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_byte_half,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [15:0] dma_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_in,
  output logic        mem_we,
  output logic        mem_byte_half,
  input  logic [15:0] mem_out
);

  localparam int LAT_W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(MEM_LATENCY);
  localparam logic [3:0]       MAX_HOLD_V = 4'(MAX_HOLD);

  typedef enum logic { S_IDLE, S_WAIT } state_t;
  typedef enum logic { OWN_CPU, OWN_DMA } owner_t;

  state_t           state_q, state_d;
  owner_t           owner_q, owner_d;
  logic [3:0]       hold_q, hold_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [15:0]      txn_addr, txn_wdata;
  logic             txn_bh;
  logic             pick_cpu, pick_dma;

  // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    hold_d        = hold_q;
    lat_d         = lat_q;
    pick_cpu      = 1'b0;
    pick_dma      = 1'b0;
    cpu_gnt       = 1'b0;
    dma_gnt       = 1'b0;
    cpu_rvalid    = 1'b0;
    dma_rvalid    = 1'b0;
    cpu_rdata     = '0;
    dma_rdata     = '0;
    mem_addr      = '0;
    mem_in        = '0;
    mem_we        = 1'b0;
    mem_byte_half = 1'b0;
    // NOTE: outputs are combinational from state and inputs, so they are gated by rst_n to read 0 during reset.
    if (rst_n) begin
      case (state_q)
        S_IDLE: begin
          pick_dma = dma_req && (!cpu_req || hold_q == MAX_HOLD_V);
          pick_cpu = cpu_req && !pick_dma;
          if (pick_cpu || pick_dma) begin
            cpu_gnt       = pick_cpu;
            dma_gnt       = pick_dma;
            mem_addr      = pick_dma ? dma_addr      : cpu_addr;
            mem_in        = pick_dma ? dma_wdata     : cpu_wdata;
            mem_we        = pick_dma ? dma_we        : cpu_we;
            mem_byte_half = pick_dma ? dma_byte_half : cpu_byte_half;
            owner_d       = pick_dma ? OWN_DMA : OWN_CPU;
            if (pick_cpu && dma_req)
              hold_d = (hold_q == MAX_HOLD_V) ? hold_q : hold_q + 4'd1;
            else
              hold_d = 4'd0;
            if (!mem_we) begin
              if (MEM_LATENCY == 0) begin
                cpu_rvalid = pick_cpu;
                dma_rvalid = pick_dma;
                cpu_rdata  = pick_cpu ? mem_out : 16'h0000;
                dma_rdata  = pick_dma ? mem_out : 16'h0000;
              end else begin
                state_d = S_WAIT;
                lat_d   = LAT_INIT;
              end
            end
          end
        end
        S_WAIT: begin
          mem_addr      = txn_addr;
          mem_in        = txn_wdata;
          mem_byte_half = txn_bh;
          lat_d         = lat_q - LAT_W'(1);
          if (lat_q == LAT_W'(1)) begin
            state_d    = S_IDLE;
            cpu_rvalid = (owner_q == OWN_CPU);
            dma_rvalid = (owner_q == OWN_DMA);
            cpu_rdata  = (owner_q == OWN_CPU) ? mem_out : 16'h0000;
            dma_rdata  = (owner_q == OWN_DMA) ? mem_out : 16'h0000;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_CPU;
      hold_q    <= 4'd0;
      lat_q     <= '0;
      txn_addr  <= '0;
      txn_wdata <= '0;
      txn_bh    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      lat_q   <= lat_d;
      if (cpu_gnt || dma_gnt) begin
        txn_addr  <= mem_addr;
        txn_wdata <= mem_in;
        txn_bh    <= mem_byte_half;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table for the main DUT (latency 1) and
// hand sequences for asynchronous reset and a second, zero-latency instance.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_byte_half;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        dma_req, dma_we, dma_byte_half;
  logic [15:0] dma_addr, dma_wdata;

  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_we, mem_byte_half;
  logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_in, mem_out;
  logic        z_cpu_gnt, z_cpu_rvalid, z_dma_gnt, z_dma_rvalid, z_mem_we, z_mem_byte_half;
  logic [15:0] z_cpu_rdata, z_dma_rdata, z_mem_addr, z_mem_in, z_mem_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_model(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  always_comb mem_out   = mem_model(mem_addr);
  always_comb z_mem_out = mem_model(z_mem_addr);

  mem_port_arbiter #(.MEM_LATENCY(1), .MAX_HOLD(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte_half(cpu_byte_half),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_byte_half(dma_byte_half),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_we(mem_we),
    .mem_byte_half(mem_byte_half), .mem_out(mem_out)
  );

  mem_port_arbiter #(.MEM_LATENCY(0), .MAX_HOLD(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte_half(cpu_byte_half),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(z_cpu_gnt), .cpu_rvalid(z_cpu_rvalid), .cpu_rdata(z_cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_byte_half(dma_byte_half),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(z_dma_gnt), .dma_rvalid(z_dma_rvalid), .dma_rdata(z_dma_rdata),
    .mem_addr(z_mem_addr), .mem_in(z_mem_in), .mem_we(z_mem_we),
    .mem_byte_half(z_mem_byte_half), .mem_out(z_mem_out)
  );

  typedef struct {
    logic        c_req, c_we;
    logic [15:0] c_addr, c_wd;
    logic        d_req, d_we;
    logic [15:0] d_addr, d_wd;
    logic        e_cgnt, e_dgnt, e_crv;
    logic [15:0] e_crd;
    logic        e_drv;
    logic [15:0] e_drd;
    logic        e_we, e_bh;
    logic [15:0] e_addr, e_in;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dma(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    dma_req = r; dma_we = w; dma_addr = a; dma_wdata = d;
  endtask

  initial begin
    // c_req c_we c_addr c_wd | d_req d_we d_addr d_wd | cgnt dgnt crv crd drv drd we bh addr in
    vecs[0]  = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,16'h0000,0,16'h0000,0,0,16'h0000,16'h0000};
    vecs[1]  = '{1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000, 1,0,0,16'h0000,0,16'h0000,0,1,16'h0010,16'h0000};
    vecs[2]  = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,1,16'hBEEF,0,16'h0000,0,1,16'h0010,16'h0000};
    vecs[3]  = '{0,0,16'h0000,16'h0000, 1,1,16'h0200,16'h1234, 0,1,0,16'h0000,0,16'h0000,1,0,16'h0200,16'h1234};
    vecs[4]  = '{0,0,16'h0000,16'h0000, 1,1,16'h0202,16'h5678, 0,1,0,16'h0000,0,16'h0000,1,0,16'h0202,16'h5678};
    vecs[5]  = vecs[0];
    // Both requesters reading continuously: four CPU grants, then the DMA side.
    vecs[6]  = '{1,0,16'h0010,16'h0000, 1,0,16'h0100,16'h0000, 1,0,0,16'h0000,0,16'h0000,0,1,16'h0010,16'h0000};
    vecs[7]  = '{1,0,16'h0010,16'h0000, 1,0,16'h0100,16'h0000, 0,0,1,16'hBEEF,0,16'h0000,0,1,16'h0010,16'h0000};
    vecs[8]  = vecs[6];
    vecs[9]  = vecs[7];
    vecs[10] = vecs[6];
    vecs[11] = vecs[7];
    vecs[12] = vecs[6];
    vecs[13] = vecs[7];
    vecs[14] = '{1,0,16'h0010,16'h0000, 1,0,16'h0100,16'h0000, 0,1,0,16'h0000,0,16'h0000,0,0,16'h0100,16'h0000};
    vecs[15] = '{1,0,16'h0010,16'h0000, 1,0,16'h0100,16'h0000, 0,0,0,16'h0000,1,16'h5B5A,0,0,16'h0100,16'h0000};
    vecs[16] = vecs[6];
    vecs[17] = vecs[7];
    // DMA read in WAIT while the CPU pulses its request for one cycle.
    vecs[18] = '{0,0,16'h0000,16'h0000, 1,0,16'h0300,16'h0000, 0,1,0,16'h0000,0,16'h0000,0,0,16'h0300,16'h0000};
    vecs[19] = '{1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,16'h0000,1,16'h595A,0,0,16'h0300,16'h0000};
    vecs[20] = vecs[0];
    vecs[21] = '{1,1,16'h0040,16'hABCD, 0,0,16'h0000,16'h0000, 1,0,0,16'h0000,0,16'h0000,1,1,16'h0040,16'hABCD};
    vecs[22] = '{1,1,16'h0042,16'h0F0F, 0,0,16'h0000,16'h0000, 1,0,0,16'h0000,0,16'h0000,1,1,16'h0042,16'h0F0F};
    vecs[23] = vecs[0];

    cpu_byte_half = 1'b1;
    dma_byte_half = 1'b0;
    set_cpu(0, 0, 16'h0000, 16'h0000);
    set_dma(0, 0, 16'h0000, 16'h0000);
    rst_n = 1'b0;
    #1;
    check("reset cpu_gnt",    {15'd0, cpu_gnt},    16'h0000);
    check("reset mem_addr",   mem_addr,            16'h0000);
    check("reset cpu_rdata",  cpu_rdata,           16'h0000);
    check("reset z_mem_addr", z_mem_addr,          16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    for (int i = 0; i < 24; i++) begin
      set_cpu(vecs[i].c_req, vecs[i].c_we, vecs[i].c_addr, vecs[i].c_wd);
      set_dma(vecs[i].d_req, vecs[i].d_we, vecs[i].d_addr, vecs[i].d_wd);
      @(negedge clk);
      check($sformatf("v%0d cpu_gnt", i),    {15'd0, cpu_gnt},       {15'd0, vecs[i].e_cgnt});
      check($sformatf("v%0d dma_gnt", i),    {15'd0, dma_gnt},       {15'd0, vecs[i].e_dgnt});
      check($sformatf("v%0d cpu_rvalid", i), {15'd0, cpu_rvalid},    {15'd0, vecs[i].e_crv});
      check($sformatf("v%0d cpu_rdata", i),  cpu_rdata,              vecs[i].e_crd);
      check($sformatf("v%0d dma_rvalid", i), {15'd0, dma_rvalid},    {15'd0, vecs[i].e_drv});
      check($sformatf("v%0d dma_rdata", i),  dma_rdata,              vecs[i].e_drd);
      check($sformatf("v%0d mem_we", i),     {15'd0, mem_we},        {15'd0, vecs[i].e_we});
      check($sformatf("v%0d mem_bh", i),     {15'd0, mem_byte_half}, {15'd0, vecs[i].e_bh});
      check($sformatf("v%0d mem_addr", i),   mem_addr,               vecs[i].e_addr);
      check($sformatf("v%0d mem_in", i),     mem_in,                 vecs[i].e_in);
      next_cycle();
    end

    // Asynchronous reset in the WAIT cycle of a DMA read.
    set_dma(1, 0, 16'h0300, 16'h0000);
    @(negedge clk);
    check("rst seq dma_gnt", {15'd0, dma_gnt}, 16'h0001);
    next_cycle();
    set_dma(0, 0, 16'h0000, 16'h0000);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst seq dma_rvalid", {15'd0, dma_rvalid}, 16'h0000);
    check("rst seq mem_addr",   mem_addr,            16'h0000);
    check("rst seq mem_bh",     {15'd0, mem_byte_half}, 16'h0000);
    check("rst seq dma_rdata",  dma_rdata,           16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    check("post rst dma_rvalid", {15'd0, dma_rvalid}, 16'h0000);
    next_cycle();

    // Back in IDLE: an immediate CPU read is granted; the zero-latency instance returns data at once.
    set_cpu(1, 0, 16'h0010, 16'h0000);
    @(negedge clk);
    check("post rst cpu_gnt",  {15'd0, cpu_gnt},      16'h0001);
    check("lat0 cpu_gnt a",    {15'd0, z_cpu_gnt},    16'h0001);
    check("lat0 cpu_rvalid a", {15'd0, z_cpu_rvalid}, 16'h0001);
    check("lat0 cpu_rdata a",  z_cpu_rdata,           16'hBEEF);
    next_cycle();
    set_cpu(1, 0, 16'h0004, 16'h0000);
    @(negedge clk);
    check("lat0 cpu_gnt b",    {15'd0, z_cpu_gnt},    16'h0001);
    check("lat0 cpu_rvalid b", {15'd0, z_cpu_rvalid}, 16'h0001);
    check("lat0 cpu_rdata b",  z_cpu_rdata,           16'h5A5E);
    check("lat0 mem_addr b",   z_mem_addr,            16'h0004);
    check("lat0 dma_rvalid b", {15'd0, z_dma_rvalid}, 16'h0000);
    check("lat1 wait no gnt",  {15'd0, cpu_gnt},      16'h0000);
    check("lat1 wait rdata",   cpu_rdata,             16'hBEEF);
    next_cycle();
    set_cpu(0, 0, 16'h0000, 16'h0000);
    @(negedge clk);
    check("lat0 idle rvalid",  {15'd0, z_cpu_rvalid}, 16'h0000);
    check("lat0 idle rdata",   z_cpu_rdata,           16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single 16-bit memory port between the CPU control unit (instruction fetch and load/store) and a DMA/debug requester.
- Sits between both requesters and the memory.
- Grants one transaction at a time and holds address/control stable for the transaction.
- Returns read data after a fixed memory latency.
- CPU has priority; a hold counter caps consecutive CPU grants so the DMA side cannot starve.

Parameters:
MEM_LATENCY, 1, cycles from the grant (issue) cycle to the cycle mem_out is valid; 0 means combinational read.
MAX_HOLD, 4, maximum consecutive CPU grants while dma_req is pending; range 1..15.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
cpu_req  input  1  CPU requests a transaction; held until cpu_gnt.
cpu_we  input  1  1 = write, 0 = read.
cpu_byte_half  input  1  access size, passed to mem_byte_half.
cpu_addr  input  16  byte address.
cpu_wdata  input  16  write data.
cpu_gnt  output  1  one-cycle pulse; the request is accepted and issued this cycle.
cpu_rvalid  output  1  one-cycle pulse; cpu_rdata is valid.
cpu_rdata  output  16  read data.
dma_req, dma_we, dma_byte_half, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata: same directions, widths and meanings for the DMA side.
mem_addr  output  16  memory address.
mem_in  output  16  memory write data.
mem_we  output  1  memory write enable.
mem_byte_half  output  1  memory access size.
mem_out  input  16  memory read data.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - state = IDLE; owner = CPU; hold_cnt = 0; lat_cnt = 0.
  - All gnt and rvalid outputs = 0; rdata = 0.
  - mem_we = 0; mem_addr, mem_in and mem_byte_half = 0.
- Reset mid-transaction aborts it: no rvalid is produced and the memory write is not retried.
- States: IDLE, WAIT.
- IDLE, no req:
  - mem_we = 0; mem_addr, mem_in and mem_byte_half = 0.
  - gnt = 0.
- IDLE, arbitration (combinational, same cycle):
  - Only one requester asserting req: that requester wins.
  - Both asserting req: CPU wins unless hold_cnt == MAX_HOLD, in which case DMA wins.
- IDLE, grant cycle:
  - Winner's gnt = 1.
  - mem_addr, mem_byte_half, mem_in and mem_we are driven from the winner's inputs.
  - Winner's addr/we/wdata/byte_half are latched into a transaction register.
- hold_cnt update (on each grant):
  - CPU grant with dma_req = 1: hold_cnt increments, saturating at MAX_HOLD.
  - CPU grant with dma_req = 0: hold_cnt clears.
  - Any DMA grant: hold_cnt clears.
- Write grant: the write completes in the grant cycle. No rvalid. State stays IDLE, so a new grant is possible next cycle.
- Read grant, MEM_LATENCY = 0: rvalid = 1 in the grant cycle; rdata = mem_out. State stays IDLE.
- Read grant, MEM_LATENCY >= 1:
  - Go to WAIT with lat_cnt = MEM_LATENCY.
  - In WAIT, mem_addr and mem_byte_half are driven from the latched transaction; mem_we = 0; both gnt = 0.
  - lat_cnt decrements each cycle.
  - In the WAIT cycle where lat_cnt == 1, the owner's rvalid = 1 and rdata = mem_out. Next state is IDLE.
  - Read-to-data latency: MEM_LATENCY cycles after gnt.
- rdata outputs are 0 whenever the corresponding rvalid = 0. The non-owner's rvalid is always 0.
- req handling:
  - req dropped before gnt: the request is withdrawn, with no side effect.
  - req held through gnt: that is a new request next cycle, arbitrated normally.
  - Requester inputs are sampled only in the grant cycle.
- Throughput:
  - Back-to-back writes: one per cycle.
  - Back-to-back reads: one per MEM_LATENCY + 1 cycles (MEM_LATENCY >= 1); one per cycle when MEM_LATENCY = 0.
- Simultaneous req from both sides in WAIT: neither is granted until IDLE.

Test Plan:
1. Reset, then CPU read of addr 0x0010 with mem model returning 0xBEEF, MEM_LATENCY = 1 -> cpu_gnt in cycle 0, mem_addr = 0x0010 for cycles 0-1, cpu_rvalid with cpu_rdata = 0xBEEF in cycle 1, dma_rvalid stays 0.
2. Continuous cpu_req (reads) and dma_req, MAX_HOLD = 4, MEM_LATENCY = 1 -> grant sequence CPU,CPU,CPU,CPU,DMA,CPU... with each grant 2 cycles apart; hold_cnt clears after the DMA grant.
3. DMA write addr 0x0200 data 0x1234 with no CPU req -> dma_gnt, mem_we = 1, mem_addr = 0x0200, mem_in = 0x1234 for one cycle; a second DMA write is granted the next cycle; no rvalid.
4. MEM_LATENCY = 0, CPU read of 0x0004 -> cpu_gnt and cpu_rvalid in the same cycle, cpu_rdata = mem_out.
5. rst_n pulled low in WAIT of a DMA read -> all outputs 0 immediately (asynchronous), no dma_rvalid after release, state IDLE.
6. cpu_req pulsed for one cycle while a DMA read is in WAIT -> cpu_gnt never asserts, memory outputs unaffected.
